// File: rtl/sparc_pipe_pkg.sv
// Shared SPARC pipeline constants: the NOP encoding, instruction field positions
// and a decode helper reused by every stage that needs register/branch fields.
package sparc_pipe_pkg;

  localparam logic [31:0] SPARC_NOP = 32'h0100_0000;

  // Field positions within a 32-bit SPARC instruction word (LSB and width).
  localparam int RS1_LSB    = 14;
  localparam int RS1_W      = 5;
  localparam int RS2_LSB    = 0;
  localparam int RS2_W      = 5;
  localparam int RD_LSB     = 25;
  localparam int RD_W       = 5;
  localparam int COND_LSB   = 25;
  localparam int COND_W     = 4;
  localparam int A_BIT      = 29;
  localparam int IMM22_LSB  = 0;
  localparam int IMM22_W    = 22;
  localparam int DISP30_LSB = 0;
  localparam int DISP30_W   = 30;

  typedef struct packed {
    logic [RS1_W-1:0]    rs1;
    logic [RS2_W-1:0]    rs2;
    logic [RD_W-1:0]     rd;
    logic [COND_W-1:0]   cond;
    logic                a;
    logic [IMM22_W-1:0]  imm22;
    logic [DISP30_W-1:0] disp30;
  } sparc_fields_t;

  function automatic sparc_fields_t decode_fields(input logic [31:0] instr);
    sparc_fields_t f;
    f.rs1    = instr[RS1_LSB +: RS1_W];
    f.rs2    = instr[RS2_LSB +: RS2_W];
    f.rd     = instr[RD_LSB +: RD_W];
    f.cond   = instr[COND_LSB +: COND_W];
    f.a      = instr[A_BIT];
    f.imm22  = instr[IMM22_LSB +: IMM22_W];
    f.disp30 = instr[DISP30_LSB +: DISP30_W];
    return f;
  endfunction

endpackage

// File: rtl/sparc_instr_fields.sv
// Purely combinational SPARC instruction field extraction, shared by any stage
// that needs rs1/rs2/rd/cond/annul/immediate views of an instruction word.
module sparc_instr_fields
  import sparc_pipe_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [3:0]  cond,
  output logic        a,
  output logic [21:0] imm22,
  output logic [29:0] disp30
);

  sparc_fields_t f;

  always_comb begin
    f      = decode_fields(instr);
    rs1    = f.rs1;
    rs2    = f.rs2;
    rd     = f.rd;
    cond   = f.cond;
    a      = f.a;
    imm22  = f.imm22;
    disp30 = f.disp30;
  end

endmodule

// File: rtl/pipeline_stage_skid.sv
// Two-entry (main + skid) pipeline stage with load enable, flush and SPARC field
// decode. Defining PIPE_PERF_CNT_EN adds saturating stall_cnt/flush_cnt outputs.
module pipeline_stage_skid
  import sparc_pipe_pkg::*;
#(
  parameter int          WIDTH   = 32,
  parameter int          PC_W    = 32,
  parameter logic [31:0] NOP_VAL = SPARC_NOP,
  parameter int          DECODE  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             LE,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PC_W-1:0]  in_pc,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [WIDTH-1:0] out_data,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [3:0]       out_cond,
  output logic             out_a,
  output logic [21:0]      out_imm22,
  output logic [29:0]      out_disp30
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      flush_cnt
`endif
);

  localparam logic [WIDTH-1:0] NOP_W = WIDTH'(NOP_VAL);

  logic             main_valid;
  logic [PC_W-1:0]  main_pc;
  logic [WIDTH-1:0] main_data;
  logic             skid_valid;
  logic [PC_W-1:0]  skid_pc;
  logic [WIDTH-1:0] skid_data;

  logic accept;
  logic retire;
  logic load_main;

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high. in_ready depends only on LE and registered state, never on out_ready;
  // the skid entry absorbs the one beat that arrives while main is blocked.
  always_comb begin
    in_ready  = LE && !skid_valid;
    out_valid = main_valid;
    accept    = in_valid && in_ready && !flush;
    retire    = main_valid && out_ready && LE;
    // accept implies skid empty, so only main's occupancy decides the target
    load_main = !main_valid || retire;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_pc    <= '0;
      main_data  <= NOP_W;
      skid_pc    <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_pc    <= '0;
      main_data  <= NOP_W;
    end else if (LE) begin
      if (retire) begin
        if (skid_valid) begin
          main_pc    <= skid_pc;
          main_data  <= skid_data;
          skid_valid <= 1'b0;
        end else if (!accept) begin
          // payload is kept so out_data/out_pc show the last retired entry
          main_valid <= 1'b0;
        end
      end
      if (accept) begin
        if (load_main) begin
          main_valid <= 1'b1;
          main_pc    <= in_pc;
          main_data  <= in_data;
        end else begin
          skid_valid <= 1'b1;
          skid_pc    <= in_pc;
          skid_data  <= in_data;
        end
      end
    end
  end

  assign out_pc   = main_pc;
  assign out_data = main_data;

  generate
    if (DECODE != 0) begin : g_decode
      sparc_instr_fields u_fields (
        .instr  (main_data[31:0]),
        .rs1    (out_rs1),
        .rs2    (out_rs2),
        .rd     (out_rd),
        .cond   (out_cond),
        .a      (out_a),
        .imm22  (out_imm22),
        .disp30 (out_disp30)
      );
    end else begin : g_no_decode
      assign out_rs1    = '0;
      assign out_rs2    = '0;
      assign out_rd     = '0;
      assign out_cond   = '0;
      assign out_a      = 1'b0;
      assign out_imm22  = '0;
      assign out_disp30 = '0;
    end
  endgenerate

`ifdef PIPE_PERF_CNT_EN
  // Counters observe raw pins, so stalls are counted even while LE is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (main_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
      if (flush && (flush_cnt != 32'hFFFF_FFFF))
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_stage_skid.sv
// Bench for pipeline_stage_skid: directed scenarios followed by random traffic,
// all compared against an in-order two-slot queue model of the stage.
module tb_pipeline_stage_skid;

  localparam logic [31:0] NOP = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        reset, LE, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_data, out_pc, out_data;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [3:0]  out_cond;
  logic        out_a;
  logic [21:0] out_imm22;
  logic [29:0] out_disp30;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // model state: held entries in order, plus what out_* shows once empty
  logic [31:0] exp_q[$];
  logic [31:0] pc_q[$];
  logic [31:0] last_d, last_p;
  logic [31:0] exp_stall, exp_flush;
  bit          known = 0;

  always #5 clk = ~clk;

  pipeline_stage_skid dut (
    .clk(clk), .reset(reset), .LE(LE), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_data(out_data),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_cond(out_cond),
    .out_a(out_a), .out_imm22(out_imm22), .out_disp30(out_disp30)
`ifdef PIPE_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance, update the model, compare every output.
  task automatic step(input logic rst, input logic le, input logic fl, input logic iv,
                      input logic [31:0] ipc, input logic [31:0] idat, input logic ordy);
    logic [31:0] d, p;
    int n;
    reset = rst; LE = le; flush = fl; in_valid = iv;
    in_pc = ipc; in_data = idat; out_ready = ordy;
    #1;
    n = exp_q.size();
    if (known) chk("in_ready_pre", {63'd0, in_ready}, {63'd0, le && (n < 2)});
    @(posedge clk);
    if (rst) begin
      exp_q.delete(); pc_q.delete();
      last_d = NOP; last_p = 32'd0;
      exp_stall = 32'd0; exp_flush = 32'd0;
      known = 1;
    end else begin
      if ((n > 0) && !ordy && (exp_stall != 32'hFFFF_FFFF)) exp_stall++;
      if (fl && (exp_flush != 32'hFFFF_FFFF)) exp_flush++;
      if (fl) begin
        exp_q.delete(); pc_q.delete();
        last_d = NOP; last_p = 32'd0;
      end else begin
        if ((n > 0) && ordy && le) begin
          last_d = exp_q.pop_front();
          last_p = pc_q.pop_front();
        end
        if (iv && le && (n < 2)) begin
          exp_q.push_back(idat);
          pc_q.push_back(ipc);
        end
      end
    end
    #1;
    n = exp_q.size();
    d = (n > 0) ? exp_q[0] : last_d;
    p = (n > 0) ? pc_q[0] : last_p;
    chk("in_ready",   {63'd0, in_ready},   {63'd0, le && (n < 2)});
    chk("out_valid",  {63'd0, out_valid},  {63'd0, n > 0});
    chk("out_pc",     {32'd0, out_pc},     {32'd0, p});
    chk("out_data",   {32'd0, out_data},   {32'd0, d});
    chk("out_rs1",    {59'd0, out_rs1},    {59'd0, 5'((d >> 14) & 32'h1F)});
    chk("out_rs2",    {59'd0, out_rs2},    {59'd0, 5'(d & 32'h1F)});
    chk("out_rd",     {59'd0, out_rd},     {59'd0, 5'((d >> 25) & 32'h1F)});
    chk("out_cond",   {60'd0, out_cond},   {60'd0, 4'((d >> 25) & 32'hF)});
    chk("out_a",      {63'd0, out_a},      {63'd0, d[29]});
    chk("out_imm22",  {42'd0, out_imm22},  {42'd0, 22'(d & 32'h3F_FFFF)});
    chk("out_disp30", {34'd0, out_disp30}, {34'd0, 30'(d & 32'h3FFF_FFFF)});
`ifdef PIPE_PERF_CNT_EN
    chk("stall_cnt", {32'd0, stall_cnt}, {32'd0, exp_stall});
    chk("flush_cnt", {32'd0, flush_cnt}, {32'd0, exp_flush});
`endif
  endtask

  initial begin
    // reset, then first cycle after reset: in_ready=LE, out_valid=0, NOP payload
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    chk("rst_data", {32'd0, out_data}, {32'd0, NOP});
    chk("rst_ready", {63'd0, in_ready}, 64'd1);

    // single entry, one-cycle latency, decoded fields
    step(0, 1, 0, 1, 32'h40, 32'h8200_4003, 1);
    chk("lat_valid", {63'd0, out_valid}, 64'd1);
    chk("lat_pc", {32'd0, out_pc}, 64'h40);
    chk("lat_rs1", {59'd0, out_rs1}, 64'd1);
    chk("lat_rs2", {59'd0, out_rs2}, 64'd3);
    chk("lat_rd", {59'd0, out_rd}, 64'd1);
    step(0, 1, 0, 0, 0, 0, 1);
    chk("retired_hold", {32'd0, out_data}, 64'h8200_4003);

    // skid fill and drain
    step(0, 1, 0, 1, 32'h100, 32'h1, 0);
    step(0, 1, 0, 1, 32'h104, 32'h2, 0);
    chk("skid_main", {32'd0, out_data}, 64'h1);
    chk("skid_full", {63'd0, in_ready}, 64'd0);
    step(0, 1, 0, 0, 0, 0, 1);
    chk("drain_b", {32'd0, out_data}, 64'h2);
    step(0, 1, 0, 0, 0, 0, 1);
    chk("drain_empty", {63'd0, out_valid}, 64'd0);
    chk("drain_ready", {63'd0, in_ready}, 64'd1);

    // flush of a full stage with a same-cycle input
    step(0, 1, 0, 1, 32'h200, 32'hA, 0);
    step(0, 1, 0, 1, 32'h204, 32'hB, 0);
    step(0, 1, 1, 1, 32'h208, 32'hC, 0);
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_data", {32'd0, out_data}, {32'd0, NOP});
    chk("flush_pc", {32'd0, out_pc}, 64'd0);
    step(0, 1, 0, 0, 0, 0, 1);
    chk("flush_no_c", {63'd0, out_valid}, 64'd0);

    // LE=0 freezes everything, then flow resumes without duplicates
    step(0, 1, 0, 1, 32'h300, 32'hAA, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 32'h304, 32'hCC, 1);
      chk("le0_data", {32'd0, out_data}, 64'hAA);
      chk("le0_ready", {63'd0, in_ready}, 64'd0);
    end
    step(0, 1, 0, 1, 32'h304, 32'hCC, 1);
    chk("le1_data", {32'd0, out_data}, 64'hCC);
    step(0, 1, 0, 0, 0, 0, 1);
    chk("le1_nodup", {63'd0, out_valid}, 64'd0);

    // reset beats flush with the skid full
    step(0, 1, 0, 1, 32'h400, 32'h11, 0);
    step(0, 1, 0, 1, 32'h404, 32'h22, 0);
    step(1, 1, 1, 1, 32'h408, 32'h33, 0);
    chk("rstfl_valid", {63'd0, out_valid}, 64'd0);
    chk("rstfl_ready", {63'd0, in_ready}, 64'd1);

`ifdef PIPE_PERF_CNT_EN
    step(0, 1, 0, 1, 32'h500, 32'h55, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 1);
    step(0, 1, 1, 0, 0, 0, 1);
    chk("perf_stall", {32'd0, stall_cnt}, 64'd5);
    chk("perf_flush", {32'd0, flush_cnt}, 64'd2);
`endif

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 1)),
           $urandom & 32'hFFFF_FFFC,
           $urandom,
           ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
